// File: rtl/ddr2_port_arbiter.sv
// rtl/ddr2_port_arbiter.sv - two-port round-robin arbiter in front of a DDR2 controller
module ddr2_port_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data_in,
    input  logic [DATA_W-1:0] m_data_out,
    output logic              m_rd_req,
    output logic              m_wr_req,
    input  logic              m_rdy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The counter holds the number of WAIT cycles already spent, so the
    // abort fires on the cycle where the TIMEOUT-th WAIT cycle is sampled.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic              grant;
    logic              last_served;
    logic              we_r;
    logic [CNT_W-1:0]  wait_cnt;

    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Round-robin choice: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        if (p0_req && p1_req) begin
            pick = ~last_served;
        end else begin
            pick = p1_req;
        end
        sel_we    = pick ? p1_we    : p0_we;
        sel_addr  = pick ? p1_addr  : p0_addr;
        sel_wdata = pick ? p1_wdata : p0_wdata;
    end

    // Transaction sequencing: grant, command pulse, completion wait and response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= 1'b0;
            last_served <= 1'b1;
            we_r        <= 1'b0;
            wait_cnt    <= '0;
            m_rd_req    <= 1'b0;
            m_wr_req    <= 1'b0;
            m_addr      <= '0;
            m_data_in   <= '0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_err      <= 1'b0;
            p1_err      <= 1'b0;
        end else begin
            m_rd_req <= 1'b0;
            m_wr_req <= 1'b0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p1_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        grant     <= pick;
                        we_r      <= sel_we;
                        m_addr    <= sel_addr;
                        m_data_in <= sel_wdata;
                        m_rd_req  <= ~sel_we;
                        m_wr_req  <= sel_we;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // m_rdy is checked first so it wins over a simultaneous timeout
                    if (m_rdy) begin
                        p0_ack      <= ~grant;
                        p1_ack      <= grant;
                        last_served <= grant;
                        state       <= S_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        p0_err      <= ~grant;
                        p1_err      <= grant;
                        last_served <= grant;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // One dead cycle so a req still held during its ack is not re-granted
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-data capture for the granted port; writes and aborts leave rdata untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (state == S_WAIT && m_rdy && !we_r) begin
            if (grant) begin
                p1_rdata <= m_data_out;
            end else begin
                p0_rdata <= m_data_out;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// tb/tb_ddr2_port_arbiter.sv - scoreboard bench for ddr2_port_arbiter
`timescale 1ns/1ps
module tb_ddr2_port_arbiter;

    localparam int AW = 26;
    localparam int DW = 64;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p0_err, p1_ack, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data_in;
    logic [DW-1:0] m_data_out = '0;
    logic          m_rd_req, m_wr_req;
    logic          m_rdy = 1'b0;

    ddr2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_data_out(m_data_out),
        .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_rdy(m_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        bit            err;
        logic [DW-1:0] rdata0;
        logic [DW-1:0] rdata1;
        int            cyc;
    } exp_t;

    typedef struct {
        int            delay;
        logic [DW-1:0] data;
    } rsp_t;

    exp_t          exp_q[$];
    rsp_t          rsp_q[$];

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            last_served = 1;
    int            rsp_mode = 0;
    bit            use_fix = 1'b0;
    logic [DW-1:0] fix_data = '0;
    bit            noise_en = 1'b0;
    bit [1:0]      prev_req = 2'b00;
    bit            prev_cmd = 1'b0;
    bit [1:0]      granted = 2'b00;
    logic [DW-1:0] model_rdata [2];
    bit            out_we [2];
    logic [AW-1:0] out_addr [2];
    logic [DW-1:0] out_wdata [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rsp_q.delete();
        last_served    = 1;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        granted        = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pulses"}, 64'({p0_ack, p1_ack, p0_err, p1_err, m_rd_req, m_wr_req}), 64'd0);
        chk({tag, "_m_addr"}, 64'(m_addr), 64'd0);
        chk({tag, "_m_data_in"}, m_data_in, 64'd0);
        chk({tag, "_p0_rdata"}, p0_rdata, 64'd0);
        chk({tag, "_p1_rdata"}, p1_rdata, 64'd0);
    endtask

    task automatic drive_req(input int n, input logic v);
        if (n == 0) p0_req = v;
        else        p1_req = v;
    endtask

    task automatic drive_port(input int n, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        out_we[n]    = we;
        out_addr[n]  = a;
        out_wdata[n] = d;
        granted[n]   = 1'b0;
        if (n == 0) begin
            p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
        end
    endtask

    // One port transaction: raise req, wait for ack/err (optionally dropping req once granted), release
    task automatic port_txn(input int n, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit early);
        int budget;
        bit done;
        @(posedge clk); #1;
        drive_port(n, we, a, d);
        done   = 1'b0;
        budget = 0;
        while (!done && budget < 60) begin
            @(negedge clk);
            budget++;
            if (n == 0 ? (p0_ack | p0_err) : (p1_ack | p1_err)) done = 1'b1;
            else if (early && granted[n]) drive_req(n, 1'b0);
        end
        if (!done) chk($sformatf("handshake_bound_p%0d", n), 64'(done), 64'd1);
        @(posedge clk); #1;
        drive_req(n, 1'b0);
    endtask

    task automatic port_loop(input int n, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            port_txn(n, 1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom},
                     $urandom_range(0, 3) == 0);
        end
    endtask

    // Controller model: answers each command after its chosen delay, optional stray m_rdy otherwise
    task automatic controller();
        rsp_t r;
        forever begin
            @(posedge clk); #1;
            m_rdy = 1'b0;
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                if (r.delay < TO) begin
                    repeat (r.delay) @(posedge clk);
                    #1;
                    m_rdy      = 1'b1;
                    m_data_out = r.data;
                end else begin
                    repeat (TO) @(posedge clk);
                end
            end else if (noise_en && $urandom_range(0, 3) == 0) begin
                m_rdy      = 1'b1;
                m_data_out = {$urandom, $urandom};
            end
        end
    endtask

    // Monitor: checks commands against the arbitration rule, queues the expected response, checks responses
    task automatic monitor();
        exp_t     e;
        rsp_t     r;
        int       p;
        int       d;
        bit       cmd;
        bit       xerr;
        logic [3:0] got;
        logic [3:0] want;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_cmd = 1'b0;
                prev_req = {p1_req, p0_req};
                continue;
            end
            cmd = m_rd_req | m_wr_req;
            if (cmd) begin
                chk("cmd_one_pulse", 64'({m_rd_req & m_wr_req, prev_cmd}), 64'd0);
                p = (prev_req == 2'b11) ? (1 - last_served) : (prev_req[1] ? 1 : 0);
                last_served = p;
                granted[p]  = 1'b1;
                chk($sformatf("cmd_addr_p%0d", p), 64'(m_addr), 64'(out_addr[p]));
                chk($sformatf("cmd_dir_p%0d", p), 64'({m_wr_req, m_rd_req}), out_we[p] ? 64'd2 : 64'd1);
                chk($sformatf("cmd_wdata_p%0d", p), m_data_in, out_wdata[p]);
                if (rsp_mode >= 0) d = rsp_mode;
                else d = ($urandom_range(0, 5) == 0) ? TO : int'($urandom_range(0, TO - 1));
                r.delay = d;
                r.data  = use_fix ? fix_data : {$urandom, $urandom};
                rsp_q.push_back(r);
                xerr = (d >= TO);
                if (!xerr && !out_we[p]) model_rdata[p] = r.data;
                e.port   = p;
                e.err    = xerr;
                e.rdata0 = model_rdata[0];
                e.rdata1 = model_rdata[1];
                e.cyc    = xerr ? cyc + TO + 1 : cyc + d + 2;
                exp_q.push_back(e);
            end
            prev_cmd = cmd;
            got = {p1_err, p0_err, p1_ack, p0_ack};
            if (got != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 64'(got), 64'd0);
                end else begin
                    e    = exp_q.pop_front();
                    want = e.err ? (e.port == 1 ? 4'b1000 : 4'b0100) : (e.port == 1 ? 4'b0010 : 4'b0001);
                    chk("resp_kind_err1_err0_ack1_ack0", 64'(got), 64'(want));
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_p0_rdata", p0_rdata, e.rdata0);
                    chk("resp_p1_rdata", p1_rdata, e.rdata1);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                e    = exp_q.pop_front();
                want = e.err ? (e.port == 1 ? 4'b1000 : 4'b0100) : (e.port == 1 ? 4'b0010 : 4'b0001);
                chk("missing_response", 64'(got), 64'(want));
            end
            prev_req = {p1_req, p0_req};
        end
    endtask

    task automatic stimulus();
        int budget;
        model_reset();
        rsp_mode = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Both ports request continuously: first tie to p0, then strict alternation
        rsp_mode = 0;
        @(posedge clk); #1;
        drive_port(0, 1'b0, 26'h0000AAA, 64'h0);
        drive_port(1, 1'b1, 26'h0000BBB, 64'h1111_2222_3333_4444);
        repeat (24) @(posedge clk);
        #1;
        drive_req(0, 1'b0);
        drive_req(1, 1'b0);
        repeat (8) @(posedge clk);

        // p0 read answered four cycles after the command pulse
        rsp_mode = 3;
        use_fix  = 1'b1;
        fix_data = 64'hDEADBEEF_CAFEF00D;
        port_txn(0, 1'b0, 26'h0000123, 64'h0, 1'b0);
        use_fix  = 1'b0;
        chk("p0_rdata_fixed", p0_rdata, 64'hDEADBEEF_CAFEF00D);

        // p1 write to top address; rdata of both ports unchanged
        rsp_mode = 1;
        port_txn(1, 1'b1, 26'h3FFFFFF, 64'h1, 1'b0);

        // Timeout abort then a normal read
        rsp_mode = TO;
        port_txn(0, 1'b0, 26'h0000456, 64'h0, 1'b0);
        rsp_mode = 2;
        port_txn(0, 1'b0, 26'h0000457, 64'h0, 1'b0);

        // Stray m_rdy in IDLE is ignored; m_rdy on the timeout cycle completes normally
        repeat (2) @(posedge clk);
        #2;
        m_rdy      = 1'b1;
        m_data_out = 64'h0BAD_0BAD_0BAD_0BAD;
        repeat (4) @(posedge clk);
        rsp_mode = TO - 1;
        port_txn(0, 1'b0, 26'h0000789, 64'h0, 1'b0);

        // Randomised traffic on both ports with stray m_rdy pulses and early req drops
        rsp_mode = -1;
        noise_en = 1'b1;
        fork
            port_loop(0, 25);
            port_loop(1, 25);
        join
        noise_en = 1'b0;
        repeat (TO + 6) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Reset during WAIT abandons the transaction silently
        rsp_mode = TO;
        @(posedge clk); #1;
        drive_port(0, 1'b0, 26'h0000321, 64'h0);
        budget = 0;
        while (!granted[0] && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("abort_grant_seen", 64'(granted[0]), 64'd1);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_abort");
        model_reset();
        drive_req(0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (TO + 4) @(posedge clk);
        rsp_mode = 2;
        port_txn(1, 1'b0, 26'h0000654, 64'h0, 1'b0);
        repeat (4) @(posedge clk);
        chk("final_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        out_we[0] = 1'b0; out_we[1] = 1'b0;
        out_addr[0] = '0; out_addr[1] = '0;
        out_wdata[0] = '0; out_wdata[1] = '0;
        fork
            controller();
            monitor();
            stimulus();
            begin
                #200000;
                checks++;
                errors++;
                $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr2_port_arbiter.md
DDR2_PORT_ARBITER -- requirements
Module: ddr2_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 26, meaning address width of ports and controller side.
REQ-002 Parameter DATA_W, default 64, meaning data width of ports and controller side.
REQ-003 Parameter TIMEOUT, default 1023, meaning the maximum number of WAIT cycles before a transaction aborts.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports p0_req, p1_req  in  1 each  port transaction request, level, held until ack or err.
REQ-007 Ports p0_we, p1_we  in  1 each  1 = write, 0 = read; stable while req high.
REQ-008 Ports p0_addr, p1_addr  in  ADDR_W each  transaction address; stable while req high.
REQ-009 Ports p0_wdata, p1_wdata  in  DATA_W each  write data; stable while req high.
REQ-010 Ports p0_ack, p1_ack  out  1 each  one-cycle completion pulse.
REQ-011 Ports p0_err, p1_err  out  1 each  one-cycle timeout-abort pulse.
REQ-012 Ports p0_rdata, p1_rdata  out  DATA_W each  read data, valid from the ack cycle until the next read completes on that port.
REQ-013 Port m_addr  out  ADDR_W  address to DDR2 controller (c_addr).
REQ-014 Port m_data_in  out  DATA_W  write data to controller (c_data_in).
REQ-015 Port m_data_out  in  DATA_W  read data from controller (c_data_out).
REQ-016 Ports m_rd_req, m_wr_req  out  1 each  one-cycle command pulses to controller.
REQ-017 Port m_rdy  in  1  controller one-cycle completion pulse; read data valid on m_data_out in the same cycle.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-020 In IDLE, when any req is high, the arbiter SHALL grant one port, latch its we/addr/wdata into m_addr/m_data_in and a we register, and go to ISSUE; when no req is high, it SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: a single requester wins; when both request, the port not served last wins; after reset port 0 wins the first tie.
REQ-022 The last-served pointer SHALL update when a transaction enters DONE, whether it ends in ack or err.
REQ-023 ISSUE SHALL last exactly one cycle with exactly one of m_rd_req/m_wr_req high, selected by the latched we; the FSM then goes to WAIT.
REQ-024 In WAIT, m_rdy high SHALL latch completion, load m_data_out into the granted port's rdata for reads only (writes leave rdata unchanged), and move the FSM to DONE.
REQ-025 A WAIT-cycle counter SHALL clear on WAIT entry and increment each WAIT cycle; when it reaches TIMEOUT without m_rdy, the FSM SHALL go to DONE flagged as error.
REQ-026 When m_rdy and the timeout occur in the same cycle, m_rdy SHALL win and the transaction completes normally.
REQ-027 In DONE, granted pN_ack (or pN_err if flagged) SHALL be high for exactly that one cycle; the FSM then goes to IDLE.
REQ-028 The one-cycle DONE gap SHALL guarantee that a req still high in the ack cycle is not re-granted.
REQ-029 m_rdy SHALL be ignored outside WAIT.
REQ-030 Minimum latency SHALL be 3 cycles: req sampled in IDLE at edge E0, ISSUE, m_rdy sampled at E2, ack visible after E2.
REQ-031 A req deasserted by a port while it is granted SHALL NOT abort the in-flight transaction; ack/err is still pulsed.
REQ-032 m_addr/m_data_in SHALL hold their values from IDLE exit until the next grant.

Reset
REQ-033 While rst_n is low: state IDLE, all ack/err/m_rd_req/m_wr_req 0, m_addr/m_data_in/p0_rdata/p1_rdata 0, counter 0, pointer favouring port 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no ack/err pulse; the first post-reset grant follows REQ-020.

Verification
REQ-035 p0 read addr 0x0000123, controller m_rdy 4 cycles after m_rd_req, m_data_out 0xDEADBEEF_CAFEF00D -> one m_rd_req pulse, m_addr 0x0000123, p0_ack one pulse, p0_rdata 0xDEADBEEF_CAFEF00D.
REQ-036 p0 and p1 both request continuously from reset, controller answers each in 1 cycle -> grants alternate p0,p1,p0,p1; no port acked twice in a row.
REQ-037 p1 write addr 0x3FFFFFF, data 0x1 -> one m_wr_req pulse carrying m_addr 0x3FFFFFF and m_data_in 0x1; p1_ack pulses; p1_rdata unchanged.
REQ-038 TIMEOUT=8, controller never asserts m_rdy -> p0_err pulses after 8 WAIT cycles, no ack; next request is accepted normally.
REQ-039 m_rdy pulsed while IDLE, and again on the exact timeout cycle -> first ignored; second yields ack, not err.
REQ-040 rst_n pulled low during WAIT -> all outputs 0 immediately, no ack/err; after release, a new p1 request completes normally.
